// File: rtl/iob2axi_rd_mb_pkg.sv
// iob2axi_rd_mb_pkg: shared AXI field widths, fixed AXI attribute values and bridge state encoding
package iob2axi_rd_mb_pkg;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_LOCK_W  = 2;
    localparam int AXI_CACHE_W = 4;
    localparam int AXI_PROT_W  = 3;
    localparam int AXI_QOS_W   = 4;
    localparam int AXI_RESP_W  = 2;
    localparam logic [AXI_BURST_W-1:0] BURST_INCR       = 2'd1;
    localparam logic [AXI_CACHE_W-1:0] CACHE_MODIFIABLE = 4'd2;
    localparam logic [AXI_PROT_W-1:0]  PROT_DEFAULT     = 3'd2;
    localparam int BOUNDARY_4K = 4096;
    localparam int BOUNDARY_W  = 12;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;
endpackage

// File: rtl/iob2axi_burst_calc.sv
// iob2axi_burst_calc: size of the next INCR burst from the current address and remaining words
// Ports:
//   i_addr_lo  byte address bits below the 4 KB boundary (beat aligned)
//   i_rem      words still to transfer
//   o_beats    beats in the next burst = min(rem, MAX_BURST_LEN, words to 4 KB)
//   o_arlen    AXI arlen = beats - 1
module iob2axi_burst_calc
    import iob2axi_rd_mb_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int LEN_W         = 16,
    parameter int MAX_BURST_LEN = 256
) (
    input  logic [BOUNDARY_W-1:0] i_addr_lo,
    input  logic [LEN_W-1:0]      i_rem,
    output logic [8:0]            o_beats,
    output logic [AXI_LEN_W-1:0]  o_arlen
);
    localparam int SIZE = $clog2(DATA_W / 8);
    localparam int CW   = (LEN_W > BOUNDARY_W + 1) ? LEN_W : BOUNDARY_W + 1;
    logic [BOUNDARY_W:0] w_to4k;
    logic [BOUNDARY_W:0] w_cap;
    // 13 bits so that a page-aligned address yields the full 4096 bytes
    assign w_to4k  = (13'(BOUNDARY_4K) - {1'b0, i_addr_lo}) >> SIZE;
    assign w_cap   = (13'(MAX_BURST_LEN) < w_to4k) ? 13'(MAX_BURST_LEN) : w_to4k;
    assign o_beats = (CW'(i_rem) < CW'(w_cap)) ? 9'(i_rem) : 9'(w_cap);
    assign o_arlen = 8'(o_beats - 9'd1);
endmodule

// File: rtl/iob2axi_rd_mb.sv
// iob2axi_rd_mb: AXI4 read master splitting one native read transfer into 4 KB-safe INCR bursts
// Ports:
//   i_clk, i_rst (synchronous, active low)
//   i_run/i_addr/i_length  transfer command, taken while o_ready=1
//   o_ready/o_error        idle flag and sticky error of the last transfer
//   i_s_valid/i_s_addr     native consumer ready (address unused)
//   o_s_rdata/o_s_ready    read word and its one-cycle valid pulse
//   o_m_axi_ar* / i_m_axi_arready        AXI read address channel
//   i_m_axi_r* / o_m_axi_rready          AXI read data channel
module iob2axi_rd_mb
    import iob2axi_rd_mb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int AXI_ADDR_W    = ADDR_W,
    parameter int AXI_ID_W      = 1,
    parameter int LEN_W         = 16,
    parameter int MAX_BURST_LEN = 256
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_run,
    input  logic [AXI_ADDR_W-1:0]  i_addr,
    input  logic [LEN_W-1:0]       i_length,
    output logic                   o_ready,
    output logic                   o_error,
    input  logic                   i_s_valid,
    input  logic [ADDR_W-1:0]      i_s_addr,
    output logic [DATA_W-1:0]      o_s_rdata,
    output logic                   o_s_ready,
    output logic [AXI_ID_W-1:0]    o_m_axi_arid,
    output logic [AXI_ADDR_W-1:0]  o_m_axi_araddr,
    output logic [AXI_LEN_W-1:0]   o_m_axi_arlen,
    output logic [AXI_SIZE_W-1:0]  o_m_axi_arsize,
    output logic [AXI_BURST_W-1:0] o_m_axi_arburst,
    output logic [AXI_LOCK_W-1:0]  o_m_axi_arlock,
    output logic [AXI_CACHE_W-1:0] o_m_axi_arcache,
    output logic [AXI_PROT_W-1:0]  o_m_axi_arprot,
    output logic [AXI_QOS_W-1:0]   o_m_axi_arqos,
    output logic                   o_m_axi_arvalid,
    input  logic                   i_m_axi_arready,
    input  logic [AXI_ID_W-1:0]    i_m_axi_rid,
    input  logic [DATA_W-1:0]      i_m_axi_rdata,
    input  logic [AXI_RESP_W-1:0]  i_m_axi_rresp,
    input  logic                   i_m_axi_rlast,
    input  logic                   i_m_axi_rvalid,
    output logic                   o_m_axi_rready
);
    localparam int SIZE = $clog2(DATA_W / 8);
    state_t                 r_state;
    logic [AXI_ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]       r_rem;
    logic [AXI_LEN_W-1:0]   r_burst_len;
    logic [AXI_LEN_W-1:0]   r_beat_cnt;
    logic [8:0]             r_beats;
    logic                   r_ready;
    logic                   r_error;
    logic                   r_arvalid;
    logic                   r_s_ready;
    logic [DATA_W-1:0]      r_s_rdata;
    logic [8:0]             w_beats;
    logic [AXI_LEN_W-1:0]   w_arlen;
    logic                   w_beat;
    logic                   w_last;
    logic                   w_unused;

    iob2axi_burst_calc #(
        .DATA_W        (DATA_W),
        .LEN_W         (LEN_W),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_calc (
        .i_addr_lo (r_addr[BOUNDARY_W-1:0]),
        .i_rem     (r_rem),
        .o_beats   (w_beats),
        .o_arlen   (w_arlen)
    );

    assign w_beat   = (r_state == S_DATA) & i_m_axi_rvalid & i_s_valid;
    assign w_last   = r_beat_cnt == r_burst_len;
    assign w_unused = ^{i_s_addr, i_m_axi_rid};

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rem       <= '0;
            r_burst_len <= '0;
            r_beat_cnt  <= '0;
            r_beats     <= '0;
            r_ready     <= 1'b1;
            r_error     <= 1'b0;
            r_arvalid   <= 1'b0;
            r_s_ready   <= 1'b0;
            r_s_rdata   <= '0;
        end else begin
            r_s_ready <= w_beat;
            if (w_beat)
                r_s_rdata <= i_m_axi_rdata;
            case (r_state)
                S_IDLE: if (i_run) begin
                    r_addr  <= (i_addr >> SIZE) << SIZE;
                    r_rem   <= i_length;
                    r_error <= 1'b0;
                    if (|i_length) begin
                        r_state   <= S_ADDR;
                        r_arvalid <= 1'b1;
                        r_ready   <= 1'b0;
                    end
                end
                S_ADDR: if (i_m_axi_arready) begin
                    r_arvalid   <= 1'b0;
                    r_burst_len <= w_arlen;
                    r_beats     <= w_beats;
                    r_beat_cnt  <= '0;
                    r_state     <= S_DATA;
                end
                S_DATA: if (w_beat) begin
                    // rlast disagreeing with our own count flags an error either way; the count wins
                    if (|i_m_axi_rresp || (i_m_axi_rlast != w_last))
                        r_error <= 1'b1;
                    r_beat_cnt <= r_beat_cnt + 8'd1;
                    if (w_last) begin
                        r_rem  <= r_rem - LEN_W'(r_beats);
                        r_addr <= r_addr + (AXI_ADDR_W'(r_beats) << SIZE);
                        if (r_rem == LEN_W'(r_beats)) begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                        end else begin
                            r_state   <= S_ADDR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready         = r_ready;
    assign o_error         = r_error;
    assign o_s_rdata       = r_s_rdata;
    assign o_s_ready       = r_s_ready;
    assign o_m_axi_arid    = '0;
    assign o_m_axi_araddr  = r_addr;
    assign o_m_axi_arlen   = w_arlen;
    assign o_m_axi_arsize  = AXI_SIZE_W'(SIZE);
    assign o_m_axi_arburst = BURST_INCR;
    assign o_m_axi_arlock  = '0;
    assign o_m_axi_arcache = CACHE_MODIFIABLE;
    assign o_m_axi_arprot  = PROT_DEFAULT;
    assign o_m_axi_arqos   = '0;
    assign o_m_axi_arvalid = r_arvalid;
    assign o_m_axi_rready  = (r_state == S_DATA) & i_s_valid;
endmodule
